mips_data_mem_arbiter: RTL and testbench
========================================

Name: mips_data_mem_arbiter

Overview:
- Shares the single data memory port between two requesters.
- Port 0 is the CPU data port of mips_cpu_harvard; port 1 is a loader/debug master that preloads or inspects memory.
- Round-robin arbitration, one transaction in flight at a time.
- Fixed, parameterised access latency; ack handshake back to the granted requester.

Parameters:
- LATENCY, 1, cycles mem_read/mem_write are held asserted per access (must be >= 1).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- clk_enable  input  1  when 0, all state frozen
- m0_req  input  1  port 0 request, held until m0_ack
- m0_write  input  1  port 0: 1 = write, 0 = read
- m0_address  input  AW  port 0 byte address
- m0_writedata  input  DW  port 0 write data
- m0_readdata  output  DW  port 0 read result, valid when m0_ack=1
- m0_ack  output  1  port 0 one-cycle completion pulse
- m0_err  output  1  port 0 misalignment flag, valid with m0_ack
- m1_req, m1_write, m1_address, m1_writedata, m1_readdata, m1_ack, m1_err  same as port 0, for port 1
- mem_address  output  AW  to data memory
- mem_write  output  1  memory write strobe
- mem_read  output  1  memory read strobe
- mem_writedata  output  DW  to data memory
- mem_readdata  input  DW  from data memory, sampled on last ACCESS cycle
- busy  output  1  high in ACCESS or DONE
- last_grant  output  1  index of most recently granted port

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, all ack/err=0, mem_read=mem_write=0.
  - mem_address=0, mem_writedata=0, m0/m1_readdata=0.
  - last_grant=1, so port 0 wins the first contention.
  - Strobes deassert immediately on reset assertion, including mid-access; the aborted access is never acked.
- clk_enable=0: no state, counter or output register changes; strobes and ack hold their current values.
- FSM states IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay.
  - Exactly one req: grant that port.
  - Both req: grant the port != last_grant.
  - On grant: latch write, address and writedata; set last_grant; clear counter.
  - If address[1:0] != 0: go to DONE with err=1, no memory strobe.
  - Otherwise: go to ACCESS.
- ACCESS:
  - Drive mem_address and mem_writedata from the latched values.
  - Assert mem_write if write, else mem_read; never both.
  - Counter increments each cycle; on counter==LATENCY-1, reads capture mem_readdata into the grantee's readdata register, then go to DONE.
- DONE:
  - Grantee ack=1 for exactly one cycle; err as latched (0 for aligned).
  - Strobes 0; return to IDLE.
  - req values sampled in DONE are ignored.
- Requester protocol:
  - Drop req in the cycle after ack, or re-raise it to issue the next transaction.
  - A req still high in IDLE is a new transaction.
- Readdata on misaligned or write transactions: the grantee's readdata register is written with 0 when ack is asserted.
- Readdata hold: it is unchanged until that port's next ack.
- Non-granted port: ack/err stay 0 and readdata is unchanged.
- Latency: req high in IDLE cycle T gives ack in cycle T+LATENCY+1. Throughput is one transaction per LATENCY+2 cycles.
- Request inputs changing during ACCESS have no effect, since values are latched.

Test Plan:
- Single read, LATENCY=1: m0 read 0x00000010, memory holds 0x12345678 -> mem_read high one cycle, m0_ack at T+2, m0_readdata=0x12345678, m0_err=0.
- Write then read back, LATENCY=3: m1 writes 0xDEADBEEF to 0x20 -> mem_write high exactly 3 cycles, m1_ack at T+4. m1 then reads 0x20 -> 0xDEADBEEF.
- Contention: m0 and m1 both request every cycle after ack -> grants alternate 0,1,0,1; the first grant after reset is port 0; last_grant toggles each transaction.
- Misaligned access: m0 reads 0x00000013 -> no mem_read/mem_write ever asserted, m0_ack with m0_err=1 at T+1, m0_readdata=0.
- Reset mid-access, LATENCY=4: assert reset in the 2nd ACCESS cycle -> mem_read drops immediately; no ack ever; after release, idle with last_grant=1.
- clk_enable=0 for 5 cycles during ACCESS -> mem_read stays high and counter frozen; ack arrives 5 cycles later than nominal with correct data.

Source files
------------

// File: rtl/mips_data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU (port 0)
// and a loader/debug master (port 1); one fixed-latency transaction at a time.
module mips_data_mem_arbiter #(
  parameter int LATENCY = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clk_enable,
  input  logic          m0_req,
  input  logic          m0_write,
  input  logic [AW-1:0] m0_address,
  input  logic [DW-1:0] m0_writedata,
  output logic [DW-1:0] m0_readdata,
  output logic          m0_ack,
  output logic          m0_err,
  input  logic          m1_req,
  input  logic          m1_write,
  input  logic [AW-1:0] m1_address,
  input  logic [DW-1:0] m1_writedata,
  output logic [DW-1:0] m1_readdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [AW-1:0] mem_address,
  output logic          mem_write,
  output logic          mem_read,
  output logic [DW-1:0] mem_writedata,
  input  logic [DW-1:0] mem_readdata,
  output logic          busy,
  output logic          last_grant
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam int            CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt_q, gnt_d;
  logic          wr_q, wr_d;
  logic          last_grant_q, last_grant_d;
  logic          busy_q, busy_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] mem_address_q, mem_address_d;
  logic [DW-1:0] mem_writedata_q, mem_writedata_d;
  logic          m0_ack_q, m0_ack_d, m0_err_q, m0_err_d;
  logic          m1_ack_q, m1_ack_d, m1_err_q, m1_err_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;

  logic          sel_s;
  logic          sel_write_s;
  logic [AW-1:0] sel_addr_s;
  logic [DW-1:0] sel_wdata_s;

  // Requester selection: on contention the port that did not win last time goes.
  always_comb begin
    sel_s       = (m0_req && m1_req) ? ~last_grant_q : m1_req;
    sel_write_s = sel_s ? m1_write     : m0_write;
    sel_addr_s  = sel_s ? m1_address   : m0_address;
    sel_wdata_s = sel_s ? m1_writedata : m0_writedata;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    gnt_d           = gnt_q;
    wr_d            = wr_q;
    last_grant_d    = last_grant_q;
    mem_read_d      = mem_read_q;
    mem_write_d     = mem_write_q;
    mem_address_d   = mem_address_q;
    mem_writedata_d = mem_writedata_q;
    m0_ack_d        = 1'b0;
    m0_err_d        = 1'b0;
    m1_ack_d        = 1'b0;
    m1_err_d        = 1'b0;
    m0_rdata_d      = m0_rdata_q;
    m1_rdata_d      = m1_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d        = sel_s;
          last_grant_d = sel_s;
          wr_d         = sel_write_s;
          cnt_d        = '0;
          // Misaligned requests complete without touching memory.
          if (sel_addr_s[1:0] != 2'b00) begin
            state_d = ST_DONE;
            if (sel_s) begin
              m1_ack_d   = 1'b1;
              m1_err_d   = 1'b1;
              m1_rdata_d = '0;
            end else begin
              m0_ack_d   = 1'b1;
              m0_err_d   = 1'b1;
              m0_rdata_d = '0;
            end
          end else begin
            state_d         = ST_ACCESS;
            mem_read_d      = ~sel_write_s;
            mem_write_d     = sel_write_s;
            mem_address_d   = sel_addr_s;
            mem_writedata_d = sel_wdata_s;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = ST_DONE;
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (gnt_q) begin
            m1_ack_d   = 1'b1;
            m1_rdata_d = wr_q ? '0 : mem_readdata;
          end else begin
            m0_ack_d   = 1'b1;
            m0_rdata_d = wr_q ? '0 : mem_readdata;
          end
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d     = ST_IDLE;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; everything freezes while clk_enable is low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      gnt_q           <= 1'b0;
      wr_q            <= 1'b0;
      last_grant_q    <= 1'b1;
      busy_q          <= 1'b0;
      mem_read_q      <= 1'b0;
      mem_write_q     <= 1'b0;
      mem_address_q   <= '0;
      mem_writedata_q <= '0;
      m0_ack_q        <= 1'b0;
      m0_err_q        <= 1'b0;
      m1_ack_q        <= 1'b0;
      m1_err_q        <= 1'b0;
      m0_rdata_q      <= '0;
      m1_rdata_q      <= '0;
    end else if (clk_enable) begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      gnt_q           <= gnt_d;
      wr_q            <= wr_d;
      last_grant_q    <= last_grant_d;
      busy_q          <= busy_d;
      mem_read_q      <= mem_read_d;
      mem_write_q     <= mem_write_d;
      mem_address_q   <= mem_address_d;
      mem_writedata_q <= mem_writedata_d;
      m0_ack_q        <= m0_ack_d;
      m0_err_q        <= m0_err_d;
      m1_ack_q        <= m1_ack_d;
      m1_err_q        <= m1_err_d;
      m0_rdata_q      <= m0_rdata_d;
      m1_rdata_q      <= m1_rdata_d;
    end
  end

  assign m0_readdata   = m0_rdata_q;
  assign m0_ack        = m0_ack_q;
  assign m0_err        = m0_err_q;
  assign m1_readdata   = m1_rdata_q;
  assign m1_ack        = m1_ack_q;
  assign m1_err        = m1_err_q;
  assign mem_address   = mem_address_q;
  assign mem_write     = mem_write_q;
  assign mem_read      = mem_read_q;
  assign mem_writedata = mem_writedata_q;
  assign busy          = busy_q;
  assign last_grant    = last_grant_q;

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// Scoreboard bench for mips_data_mem_arbiter: random two-port traffic with random
// clock-enable gaps, checked against a transaction-level reference model.
module tb_mips_data_mem_arbiter;
  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset, clk_enable;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_address, m0_writedata, m1_address, m1_writedata;
  logic [31:0] m0_readdata, m1_readdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] mem_address, mem_writedata, mem_readdata;
  logic        mem_write, mem_read, busy, last_grant;

  always #5 clk = ~clk;

  mips_data_mem_arbiter #(.LATENCY(L), .AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .m0_req(m0_req), .m0_write(m0_write), .m0_address(m0_address),
    .m0_writedata(m0_writedata), .m0_readdata(m0_readdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_write(m1_write), .m1_address(m1_address),
    .m1_writedata(m1_writedata), .m1_readdata(m1_readdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .mem_address(mem_address), .mem_write(mem_write), .mem_read(mem_read),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
    .busy(busy), .last_grant(last_grant)
  );

  // Data memory attached to the arbiter (16 words).
  logic [31:0] bmem [16];
  assign mem_readdata = bmem[mem_address[5:2]];
  always @(posedge clk) if (mem_write) bmem[mem_address[5:2]] <= mem_writedata;

  typedef struct {
    bit          port;
    bit          err;
    logic [31:0] rdata;
    int          ack_e;
    int          n_rd;
    int          n_wr;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_rd [2];
  bit          mdl_last, model_on, drv_on, rand_en, en_last;
  int          en_edges, free_e, rd_cnt, wr_cnt;
  int          errors = 0, checks = 0;

  int          m_e;
  bit          m_p, m_w;
  logic [31:0] m_a, m_d;
  exp_t        m_x, c_x;
  bit          c_p;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic gen(output logic w, output logic [31:0] a, output logic [31:0] d);
    logic [3:0] idx;
    w   = 1'($urandom_range(0, 1));
    idx = 4'($urandom_range(0, 15));
    a   = {26'd0, idx, 2'b00};
    if ($urandom_range(0, 7) == 0) a[1:0] = 2'($urandom_range(1, 3));
    d   = $urandom;
  endtask

  // Reference model: transaction-level arbitration and timing, counted in enabled edges.
  always @(posedge clk) begin
    en_last = clk_enable;
    if (model_on && reset && clk_enable) begin
      m_e = en_edges;
      if (m_e >= free_e && (m0_req || m1_req)) begin
        m_p = (m0_req && m1_req) ? !mdl_last : m1_req;
        m_w = m_p ? m1_write : m0_write;
        m_a = m_p ? m1_address : m0_address;
        m_d = m_p ? m1_writedata : m0_writedata;
        mdl_last = m_p;
        m_x.port = m_p;
        if (m_a[1:0] != 2'b00) begin
          m_x.err = 1'b1; m_x.rdata = 32'd0; m_x.ack_e = m_e;
          m_x.n_rd = 0; m_x.n_wr = 0; free_e = m_e + 2;
        end else begin
          m_x.err = 1'b0; m_x.ack_e = m_e + L; free_e = m_e + L + 2;
          if (m_w) begin
            ref_mem[m_a[5:2]] = m_d;
            m_x.rdata = 32'd0; m_x.n_rd = 0; m_x.n_wr = L;
          end else begin
            m_x.rdata = ref_mem[m_a[5:2]]; m_x.n_rd = L; m_x.n_wr = 0;
          end
        end
        sbq.push_back(m_x);
      end
      en_edges = m_e + 1;
    end
  end

  // Monitor: compares each completion against the oldest expected transaction.
  always @(negedge clk) begin
    if (model_on && reset && en_last) begin
      chk("strobe_exclusive", 32'(mem_read & mem_write), 32'd0);
      rd_cnt += int'(mem_read);
      wr_cnt += int'(mem_write);
      if (m0_ack || m1_ack) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
        end else begin
          c_x = sbq.pop_front();
          c_p = m1_ack;
          chk("both_ack", 32'(m0_ack & m1_ack), 32'd0);
          chk("ack_port", 32'(c_p), 32'(c_x.port));
          chk("ack_cycle", 32'(en_edges - 1), 32'(c_x.ack_e));
          chk("err", 32'(c_p ? m1_err : m0_err), 32'(c_x.err));
          chk("other_err", 32'(c_p ? m0_err : m1_err), 32'd0);
          chk("readdata", c_p ? m1_readdata : m0_readdata, c_x.rdata);
          chk("other_readdata", c_p ? m0_readdata : m1_readdata, exp_rd[!c_p]);
          chk("strobe_cycles", {16'(rd_cnt), 16'(wr_cnt)}, {16'(c_x.n_rd), 16'(c_x.n_wr)});
          chk("last_grant", 32'(last_grant), 32'(c_x.port));
          chk("busy_in_done", 32'(busy), 32'd1);
          exp_rd[c_p] = c_x.rdata;
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end else if (sbq.size() != 0 && en_edges - 1 > sbq[0].ack_e) begin
        chk("ack_timeout", 32'(en_edges - 1), 32'(sbq[0].ack_e));
        void'(sbq.pop_front());
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Port 0 requester.
  always @(negedge clk) begin
    if (model_on && reset) begin
      if (en_last && m0_ack) begin
        if (drv_on && $urandom_range(0, 1) == 1) gen(m0_write, m0_address, m0_writedata);
        else m0_req = 1'b0;
      end else if (drv_on && !m0_req && $urandom_range(0, 3) == 0) begin
        gen(m0_write, m0_address, m0_writedata);
        m0_req = 1'b1;
      end
    end
  end

  // Port 1 requester.
  always @(negedge clk) begin
    if (model_on && reset) begin
      if (en_last && m1_ack) begin
        if (drv_on && $urandom_range(0, 1) == 1) gen(m1_write, m1_address, m1_writedata);
        else m1_req = 1'b0;
      end else if (drv_on && !m1_req && $urandom_range(0, 3) == 0) begin
        gen(m1_write, m1_address, m1_writedata);
        m1_req = 1'b1;
      end
    end
  end

  // Random clock-enable gaps.
  always @(negedge clk) if (rand_en) clk_enable = ($urandom_range(0, 9) != 0);

  task automatic drain(input string name);
    for (int i = 0; i < 400 && (sbq.size() != 0 || m0_req || m1_req || busy); i++) @(negedge clk);
    chk(name, 32'(sbq.size()) + 32'(m0_req) + 32'(m1_req) + 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b1;
    m0_req = 1'b0; m0_write = 1'b0; m0_address = 32'd0; m0_writedata = 32'd0;
    m1_req = 1'b0; m1_write = 1'b0; m1_address = 32'd0; m1_writedata = 32'd0;
    model_on = 1'b0; drv_on = 1'b0; rand_en = 1'b0; mdl_last = 1'b1;
    en_edges = 0; free_e = 0; rd_cnt = 0; wr_cnt = 0;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    for (int i = 0; i < 16; i++) begin
      m_d = $urandom;
      bmem[i] = m_d;
      ref_mem[i] = m_d;
    end
    ref_mem[4] = 32'h12345678;
    bmem[4]    = 32'h12345678;

    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_acks", {30'd0, m1_ack, m0_ack}, 32'd0);
    chk("rst_errs", {30'd0, m1_err, m0_err}, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_writedata", mem_writedata, 32'd0);
    chk("rst_m0_readdata", m0_readdata, 32'd0);
    chk("rst_m1_readdata", m1_readdata, 32'd0);
    chk("rst_last_grant", 32'(last_grant), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);

    // First contention after reset: m0 read of 0x10, m1 write of 0xDEADBEEF to 0x20.
    m0_write = 1'b0; m0_address = 32'h10; m0_req = 1'b1;
    m1_write = 1'b1; m1_address = 32'h20; m1_writedata = 32'hDEADBEEF; m1_req = 1'b1;
    model_on = 1'b1;
    reset = 1'b1;
    drain("drain_first");

    // Misaligned read and read-back of the earlier write.
    @(negedge clk);
    m0_write = 1'b0; m0_address = 32'h13; m0_req = 1'b1;
    drain("drain_misaligned");
    m1_write = 1'b0; m1_address = 32'h20; m1_req = 1'b1;
    drain("drain_readback");
    chk("readback_value", m1_readdata, 32'hDEADBEEF);

    drv_on = 1'b1; rand_en = 1'b1;
    repeat (4000) @(negedge clk);
    drv_on = 1'b0; rand_en = 1'b0; clk_enable = 1'b1;
    drain("drain_random");

    // Reset in the second access cycle aborts the transfer without an ack.
    @(negedge clk);
    m0_write = 1'b0; m0_address = 32'h10; m0_req = 1'b1;
    for (int i = 0; i < 20 && !mem_read; i++) @(negedge clk);
    chk("abort_read_started", 32'(mem_read), 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_mem_read_drop", 32'(mem_read), 32'd0);
    chk("abort_busy_drop", 32'(busy), 32'd0);
    model_on = 1'b0;
    sbq.delete();
    m0_req = 1'b0;
    rd_cnt = 0; wr_cnt = 0; en_edges = 0; free_e = 0; mdl_last = 1'b1;
    exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_on = 1'b1;
    chk("post_abort_last_grant", 32'(last_grant), 32'd1);
    repeat (10) @(negedge clk);
    chk("post_abort_idle", {30'd0, busy, m0_ack}, 32'd0);
    chk("post_abort_m0_readdata", m0_readdata, 32'd0);

    // Contention again after reset: port 0 must win first.
    m0_write = 1'b0; m0_address = 32'h08; m0_req = 1'b1;
    m1_write = 1'b0; m1_address = 32'h0C; m1_req = 1'b1;
    drain("drain_final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
